i2c_master_ctrl: RTL and testbench

//  Single-byte I2C master sequencer.
//  - Runs one transfer per request on an open-drain SCL/SDA pair: START, 7-bit address + R/W,
//    one data byte (write, or read with a master NACK), STOP.
//  - Drives the bus that the on-chip I2C slave responds to. Used as the bring-up and test

---
 rtl/i2c_master_ctrl.sv | 143 ++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+R/W, one write or read byte (read ends with a
// master NACK), STOP. Open-drain outputs are registered so the pins never glitch.
module i2c_master_ctrl #(
    parameter int DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_req,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);
    localparam int CW = $clog2(DIV);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, RNACK, STOP
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] div_cnt;
    logic [1:0]    qtr;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_sr, rx_sr, wdata_q;
    logic          rw_q;
    logic          tick, q1_end, bit_end, accept, scl_lo;
    logic          scl_d, sda_d;

    assign busy    = (state != IDLE);
    assign tick    = busy && (div_cnt == CW'(DIV - 1));
    assign q1_end  = tick && (qtr == 2'd1);
    assign bit_end = tick && (qtr == 2'd3);
    // The done cycle is already IDLE, so it must be excluded explicitly.
    assign accept  = !busy && !done && start_req;
    assign scl_lo  = (qtr == 2'd0) || (qtr == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        scl_d     = 1'b0;
        sda_d     = 1'b0;
        case (state)
            IDLE:  if (accept) state_nxt = START;
            START: begin
                scl_d = (qtr == 2'd3);
                sda_d = qtr[1];
                if (bit_end) state_nxt = ADDR;
            end
            ADDR: begin
                scl_d = scl_lo;
                sda_d = ~tx_sr[7];
                if (bit_end && bit_cnt == 3'd7) state_nxt = AACK;
            end
            AACK: begin
                scl_d = scl_lo;
                if (bit_end) state_nxt = ack_err ? STOP : (rw_q ? RDATA : WDATA);
            end
            WDATA: begin
                scl_d = scl_lo;
                sda_d = ~tx_sr[7];
                if (bit_end && bit_cnt == 3'd7) state_nxt = WACK;
            end
            WACK: begin
                scl_d = scl_lo;
                if (bit_end) state_nxt = STOP;
            end
            RDATA: begin
                scl_d = scl_lo;
                if (bit_end && bit_cnt == 3'd7) state_nxt = RNACK;
            end
            RNACK: begin
                scl_d = scl_lo;
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                scl_d = (qtr == 2'd0);
                sda_d = (qtr != 2'd3);
                if (bit_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            qtr     <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            rdata   <= '0;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
        end else begin
            done   <= (state == STOP) && bit_end;
            scl_oe <= scl_d;
            sda_oe <= sda_d;
            if (accept) begin
                rw_q    <= rw;
                wdata_q <= wdata;
                tx_sr   <= {addr, rw};
                ack_err <= 1'b0;
                div_cnt <= '0;
                qtr     <= '0;
                bit_cnt <= '0;
            end else if (busy) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) qtr <= qtr + 2'd1;
                if (q1_end) begin
                    if ((state == AACK || state == WACK) && sda_in) ack_err <= 1'b1;
                    if (state == RDATA) rx_sr <= {rx_sr[6:0], sda_in};
                end
                // bit_cnt wraps 7->0 on its own, ready for the next byte.
                if (bit_end) begin
                    case (state)
                        ADDR, WDATA: begin
                            tx_sr   <= {tx_sr[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        RDATA:   bit_cnt <= bit_cnt + 3'd1;
                        AACK:    tx_sr <= wdata_q;
                        STOP:    if (rw_q && !ack_err) rdata <= rx_sr;
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a behavioural slave on the open-drain bus plus a bus monitor
// that decodes START/STOP/bits; each transfer is compared against frame rules.
module tb_i2c_master_ctrl;
    localparam int DIV   = 4;
    localparam int LIMIT = 2000;

    logic       clk = 1'b0, rst = 1'b1, start_req = 1'b0, rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       busy, done, ack_err, scl_oe, sda_oe;
    logic [7:0] rdata;
    logic       slave_pull = 1'b0;
    logic       scl_b, sda_b;

    assign scl_b = ~scl_oe;
    assign sda_b = ~sda_oe & ~slave_pull;

    always #5 clk = ~clk;

    i2c_master_ctrl #(.DIV(DIV)) dut (
        .clk(clk), .rst(rst), .start_req(start_req), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_b)
    );

    int cyc_now = 0;
    always @(posedge clk) cyc_now++;

    // Slave behaviour and bus decode
    logic        cfg_nack_a = 1'b0, cfg_nack_d = 1'b0;
    logic [7:0]  cfg_rbyte = '0;
    int          n_start = 0, n_stop = 0, n_done = 0, nbits = 0;
    logic [31:0] obs = '0;
    logic        pend = 1'b0, pend_v = 1'b0, rd_flag = 1'b0;
    logic        prev_scl = 1'b1, prev_sda = 1'b1;

    always @(negedge clk) begin
        if (done) n_done++;
        if (scl_b && prev_scl && sda_b != prev_sda) begin
            if (!sda_b) begin
                n_start++; obs = '0; nbits = 0; pend_v = 1'b0; slave_pull = 1'b0;
            end else n_stop++;
        end
        if (!prev_scl && scl_b) begin pend = sda_b; pend_v = 1'b1; end
        if (prev_scl && !scl_b && pend_v) begin
            obs = {obs[30:0], pend}; nbits++; pend_v = 1'b0;
            if (nbits == 8) begin
                rd_flag = obs[0]; slave_pull = !cfg_nack_a;
            end else if (rd_flag && !cfg_nack_a && nbits >= 9 && nbits <= 16)
                slave_pull = !cfg_rbyte[16-nbits];
            else if (!rd_flag && nbits == 17)
                slave_pull = !cfg_nack_d;
            else
                slave_pull = 1'b0;
        end
        prev_scl = scl_b; prev_sda = sda_b;
    end

    int         n_chk = 0, n_pass = 0, n_fail = 0;
    logic [7:0] exp_rdata = '0;
    int         t0 = 0;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d);
        rw = r; addr = a; wdata = d; start_req = 1'b1;
        @(posedge clk); #1;
        start_req = 1'b0;
        t0 = cyc_now;
    endtask

    task automatic wait_done(output int lat);
        while (!done && (cyc_now - t0) < LIMIT) begin @(posedge clk); #1; end
        lat = cyc_now - t0;
    endtask

    task automatic run_xfer(input string tag, input logic r, input logic [6:0] a,
                            input logic [7:0] d, input logic na, input logic nd,
                            input logic [7:0] rb, input int mid);
        int s0, p0, d0, lat, elen;
        logic [31:0] ebits;
        logic [7:0]  abyte;
        logic        eerr;
        cfg_nack_a = na; cfg_nack_d = nd; cfg_rbyte = rb;
        s0 = n_start; p0 = n_stop; d0 = n_done;
        @(posedge clk); #1;
        issue(r, a, d);
        check({tag, ".busy_on"}, 32'(busy), 32'd1);
        if (mid > 0) begin
            repeat (mid) @(posedge clk);
            #1 start_req = 1'b1; addr = ~a;
            @(posedge clk); #1 start_req = 1'b0;
        end
        wait_done(lat);
        abyte = {a, r};
        if (na) begin
            elen = 9;  ebits = {23'd0, abyte, 1'b1}; eerr = 1'b1;
        end else if (r) begin
            elen = 18; ebits = {14'd0, abyte, 1'b0, rb, 1'b1}; eerr = 1'b0;
            exp_rdata = rb;
        end else begin
            elen = 18; ebits = {14'd0, abyte, 1'b0, d, nd}; eerr = nd;
        end
        check({tag, ".latency"}, 32'(lat), 32'(elen * 4 * DIV + (na ? 2 : 2) * 4 * DIV));
        check({tag, ".ack_err"}, 32'(ack_err), 32'(eerr));
        check({tag, ".rdata"}, 32'(rdata), 32'(exp_rdata));
        check({tag, ".busy_off"}, 32'(busy), 32'd0);
        check({tag, ".bus_rel"}, 32'({scl_oe, sda_oe}), 32'd0);
        check({tag, ".nbits"}, 32'(nbits), 32'(elen));
        check({tag, ".bits"}, obs, ebits);
        check({tag, ".starts"}, 32'(n_start - s0), 32'd1);
        check({tag, ".stops"}, 32'(n_stop - p0), 32'd1);
        #5;
        check({tag, ".dones"}, 32'(n_done - d0), 32'd1);
    endtask

    initial begin
        logic       r, na, nd;
        logic [6:0] a;
        logic [7:0] d, rb;
        int         s0, d0;

        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.ack_err", 32'(ack_err), 32'd0);
        check("rst.rdata", 32'(rdata), 32'd0);
        check("rst.bus", 32'({scl_oe, sda_oe}), 32'd0);
        rst = 1'b0;

        run_xfer("t1_write", 1'b0, 7'h42, 8'hA5, 1'b0, 1'b0, 8'h00, 0);
        run_xfer("t2_anack", 1'b0, 7'h42, 8'h77, 1'b1, 1'b0, 8'h00, 0);
        run_xfer("t3_read",  1'b1, 7'h42, 8'h00, 1'b0, 1'b0, 8'h3C, 0);
        run_xfer("t4_dnack", 1'b0, 7'h42, 8'h5A, 1'b0, 1'b1, 8'h00, 0);
        run_xfer("t5_mid",   1'b0, 7'(($urandom_range(0, 127))), 8'($urandom_range(0, 255)),
                 1'b0, 1'b0, 8'h00, 30 * DIV);
        run_xfer("t5_b2b",   1'b1, 7'h2B, 8'h00, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 0);

        // Request in the done cycle must be dropped.
        s0 = n_start;
        start_req = 1'b1;
        @(posedge clk); #1 start_req = 1'b0;
        check("t5_donecyc.busy", 32'(busy), 32'd0);
        repeat (8 * DIV) @(posedge clk);
        #1 check("t5_donecyc.starts", 32'(n_start - s0), 32'd0);

        // Reset while WDATA bit 3 is being clocked (SCL low phase).
        cfg_nack_a = 1'b0; cfg_nack_d = 1'b0;
        d0 = n_done;
        @(posedge clk); #1;
        issue(1'b0, 7'h19, 8'hC3);
        repeat (13 * 4 * DIV + 2) @(posedge clk);
        #1 check("t6.pre_busy", 32'(busy), 32'd1);
        check("t6.pre_scl", 32'(scl_oe), 32'd1);
        rst = 1'b1;
        #1;
        check("t6.rst_bus", 32'({scl_oe, sda_oe}), 32'd0);
        check("t6.rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_rdata = '0;
        repeat (100) @(posedge clk);
        #1 check("t6.no_done", 32'(n_done - d0), 32'd0);
        check("t6.rdata", 32'(rdata), 32'd0);
        run_xfer("t6_after", 1'b0, 7'h19, 8'hC3, 1'b0, 1'b0, 8'h00, 0);

        for (int i = 0; i < 8; i++) begin
            r  = 1'($urandom_range(0, 1));
            a  = 7'($urandom_range(0, 127));
            d  = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            na = ($urandom_range(0, 3) == 0);
            nd = ($urandom_range(0, 2) == 0);
            run_xfer($sformatf("rnd%0d", i), r, a, d, na, nd, rb, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
